// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding,
// MMIO register offsets, wait-counter width and a byte-merge helper.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int unsigned WAIT_CNT_W = 4;

  localparam logic [3:0] OFS_CYCLE   = 4'h0;
  localparam logic [3:0] OFS_SCRATCH = 4'h4;
  localparam logic [3:0] OFS_ACCESS  = 4'h8;

  // Replace only the bytes of old_w whose enable bit is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        res[8*b +: 8] = new_w[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_w[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core data-port bundle between the pipelined core (master) and the
// data-memory responder (slave). The byte-enable lane only exists when
// DMEM_BYTE_EN_EN is defined.
interface dmem_responder_if;
  logic        req;
  logic        we_dm;
  logic [31:0] addr;
  logic [31:0] wd_dm;
`ifdef DMEM_BYTE_EN_EN
  logic [3:0]  be;
`endif
  logic [31:0] rd_dm;
  logic        ready;
  logic        err;

  modport master (
    output req, we_dm, addr, wd_dm,
`ifdef DMEM_BYTE_EN_EN
    output be,
`endif
    input  rd_dm, ready, err
  );

  modport slave (
    input  req, we_dm, addr, wd_dm,
`ifdef DMEM_BYTE_EN_EN
    input  be,
`endif
    output rd_dm, ready, err
  );
endinterface

// File: rtl/dmem_ram.sv
// Word-organised RAM: synchronous byte-maskable write, asynchronous read
// on a single shared address. Contents are deliberately not reset.
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64
) (
  input  logic                           clk,
  input  logic                           we_i,
  input  logic [3:0]                     be_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
  input  logic [31:0]                    wdata_i,
  output logic [31:0]                    rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  // Commit enabled bytes of the write word on the clock edge.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= merge_bytes(mem_q[addr_i], wdata_i, be_i);
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the core's data port: word RAM plus a 16-byte
// MMIO window (cycle counter, scratch, access counter), req/ready handshake
// with WAIT_STATES extra cycles. Optional byte enables: DMEM_BYTE_EN_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input logic              clk,
  input logic              rst,
  dmem_responder_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [WAIT_CNT_W-1:0] CNT_INIT =
    (WAIT_STATES > 32'd0) ? WAIT_CNT_W'(WAIT_STATES - 32'd1) : {WAIT_CNT_W{1'b0}};

  state_e                 state_q, state_d;
  logic [WAIT_CNT_W-1:0]  cnt_q, cnt_d;
  logic                   accept_s;
  logic                   enter_resp_s;

  logic [31:0]            lat_addr_q;
  logic                   lat_we_q;
  logic [31:0]            lat_wd_q;
  logic [3:0]             lat_be_q;
  logic [3:0]             bus_be_s;

  logic [31:0]            acc_addr_s;
  logic                   acc_we_s;
  logic [31:0]            acc_wd_s;
  logic [3:0]             acc_be_s;

  logic                   mis_s;
  logic [31:0]            mmio_off_s;
  logic                   mmio_hit_s;
  logic                   ram_hit_s;
  logic                   sel_mmio_s;
  logic                   sel_ram_s;
  logic                   err_s;

  logic [31:0]            mmio_rdata_s;
  logic [31:0]            ram_rdata_s;
  logic [31:0]            rdata_s;
  logic                   ram_we_s;
  logic                   scratch_we_s;

  logic [31:0]            rd_dm_q;
  logic                   ready_q;
  logic                   err_q;
  logic [31:0]            cycle_q;
  logic [31:0]            access_q;
  logic [31:0]            scratch_q;

`ifdef DMEM_BYTE_EN_EN
  assign bus_be_s = bus.be;
`else
  assign bus_be_s = 4'hF;
`endif

  // Next-state logic: accept in IDLE, count down in WAIT, one RESP cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    accept_s     = 1'b0;
    enter_resp_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          accept_s = 1'b1;
          if (WAIT_STATES == 32'd0) begin
            state_d      = ST_RESP;
            enter_resp_s = 1'b1;
            cnt_d        = {WAIT_CNT_W{1'b0}};
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == {WAIT_CNT_W{1'b0}}) begin
          state_d      = ST_RESP;
          enter_resp_s = 1'b1;
        end else begin
          cnt_d = cnt_q - {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {WAIT_CNT_W{1'b0}};
      end
    endcase
  end

  // State register, wait counter and request latch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= {WAIT_CNT_W{1'b0}};
      lat_addr_q <= 32'd0;
      lat_we_q   <= 1'b0;
      lat_wd_q   <= 32'd0;
      lat_be_q   <= 4'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept_s) begin
        lat_addr_q <= bus.addr;
        lat_we_q   <= bus.we_dm;
        lat_wd_q   <= bus.wd_dm;
        lat_be_q   <= bus_be_s;
      end
    end
  end

  // Access operands: with zero wait states the access executes on the
  // accepting edge, before the latch holds the request, so use live inputs.
  always_comb begin
    acc_addr_s = lat_addr_q;
    acc_we_s   = lat_we_q;
    acc_wd_s   = lat_wd_q;
    acc_be_s   = lat_be_q;
    if (state_q == ST_IDLE) begin
      acc_addr_s = bus.addr;
      acc_we_s   = bus.we_dm;
      acc_wd_s   = bus.wd_dm;
      acc_be_s   = bus_be_s;
    end else begin
      acc_addr_s = lat_addr_q;
      acc_we_s   = lat_we_q;
      acc_wd_s   = lat_wd_q;
      acc_be_s   = lat_be_q;
    end
  end

  // Address decode in priority order: misalignment, MMIO window, RAM.
  always_comb begin
    mis_s      = (acc_addr_s[1:0] != 2'b00);
    mmio_off_s = acc_addr_s - MMIO_BASE;
    mmio_hit_s = (acc_addr_s >= MMIO_BASE) && (mmio_off_s <= 32'h0000_000C);
    ram_hit_s  = ({2'b00, acc_addr_s[31:2]} < 32'(DEPTH_WORDS));
    sel_mmio_s = !mis_s && mmio_hit_s;
    sel_ram_s  = !mis_s && !mmio_hit_s && ram_hit_s;
    err_s      = !sel_mmio_s && !sel_ram_s;
  end

  // MMIO read mux; unmapped and reserved offsets read as zero.
  always_comb begin
    mmio_rdata_s = 32'd0;
    case (mmio_off_s[3:0])
      OFS_CYCLE:   mmio_rdata_s = cycle_q;
      OFS_SCRATCH: mmio_rdata_s = scratch_q;
      OFS_ACCESS:  mmio_rdata_s = access_q;
      default:     mmio_rdata_s = 32'd0;
    endcase
  end

  // Response data source and write strobes, all qualified by RESP entry.
  always_comb begin
    rdata_s      = 32'd0;
    ram_we_s     = 1'b0;
    scratch_we_s = 1'b0;
    if (sel_mmio_s) begin
      rdata_s = mmio_rdata_s;
    end else begin
      rdata_s = ram_rdata_s;
    end
    ram_we_s     = enter_resp_s && sel_ram_s && acc_we_s;
    scratch_we_s = enter_resp_s && sel_mmio_s && acc_we_s &&
                   (mmio_off_s[3:0] == OFS_SCRATCH);
  end

  dmem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we_s),
    .be_i    (acc_be_s),
    .addr_i  (acc_addr_s[AW+1:2]),
    .wdata_i (acc_wd_s),
    .rdata_o (ram_rdata_s)
  );

  // Response registers and access counter, updated on the edge entering RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      rd_dm_q  <= 32'd0;
      access_q <= 32'd0;
    end else begin
      ready_q <= enter_resp_s;
      if (enter_resp_s) begin
        err_q    <= err_s;
        access_q <= access_q + 32'd1;
        if (err_s) begin
          rd_dm_q <= 32'd0;
        end else if (!acc_we_s) begin
          rd_dm_q <= rdata_s;
        end
      end
    end
  end

  // Free-running cycle counter, wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_q <= 32'd0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
    end
  end

  // Scratch register, byte-maskable like RAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scratch_q <= 32'd0;
    end else if (scratch_we_s) begin
      scratch_q <= merge_bytes(scratch_q, acc_wd_s, acc_be_s);
    end
  end

  assign bus.rd_dm = rd_dm_q;
  assign bus.ready = ready_q;
  assign bus.err   = err_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the pipelined MIPS core's data port. The core is the initiator: it drives address, write data and write enable, and receives read data.
- Block holds word-addressed RAM plus a small memory-mapped register window.
- Uses a req/ready handshake with configurable wait states, so the core can be exercised against multi-cycle memory and stall logic can be verified.

Parameters:
- DEPTH_WORDS, 64, RAM size in 32-bit words (power of two).
- WAIT_STATES, 1, extra cycles between request acceptance and response (0..15).
- MMIO_BASE, 32'hFFFF_0000, base byte address of the 16-byte MMIO window.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- req  input  1  access request; held stable with addr/we_dm/wd_dm until ready
- we_dm  input  1  1 = write, 0 = read
- addr  input  32  byte address (core alu_out)
- wd_dm  input  32  write data
- rd_dm  output  32  read data, registered
- ready  output  1  one-cycle response strobe
- err  output  1  access error, valid while ready=1

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, ready=0, err=0, rd_dm=0, wait counter=0, cycle counter=0, access counter=0, scratch=0. RAM is not reset; reads of unwritten words are undefined.
- FSM states: IDLE, WAIT, RESP.
- IDLE: on a clock edge with req=1, latch addr/we_dm/wd_dm. Go to WAIT with counter=WAIT_STATES-1, or to RESP directly if WAIT_STATES=0.
- WAIT: decrement the counter each cycle. Move to RESP on the edge where counter=0.
- Access execution: the access is performed on the edge entering RESP. Writes commit at that edge; rd_dm, err and the access counter update at that edge.
- RESP: ready=1 for exactly one cycle, then IDLE unconditionally. req still high in the following IDLE cycle is a new request.
- Latency: ready is high in cycle WAIT_STATES+1 after the accepting edge. Minimum spacing between ready pulses is WAIT_STATES+2 cycles.
- req changes during WAIT/RESP are ignored. A transaction is never aborted except by reset.
- Decode order:
  - addr[1:0]!=0 gives err=1.
  - Otherwise, addr in [MMIO_BASE, MMIO_BASE+0xC] selects MMIO.
  - Otherwise, addr[31:2] < DEPTH_WORDS selects RAM.
  - Anything else gives err=1.
- On err: no state change, rd_dm=0.
- MMIO map:
  - +0x0 cycle counter. Read-only, free-running from reset, wraps 2^32-1 to 0. A read returns its value at the edge entering RESP.
  - +0x4 scratch register, read/write.
  - +0x8 access counter, read-only. Counts completed transactions, including err ones. A read returns the count before the current transaction. Wraps.
  - +0xC reads 0.
  - Writes to read-only offsets are ignored, with err=0.
- On writes, rd_dm holds its previous value.
- Reset mid-transaction: return to IDLE immediately. No ready pulse and no RAM write for the aborted access.

Optional Feature:
- Macro DMEM_BYTE_EN_EN.
- When defined: adds input be[3:0]. RAM and scratch writes update only the bytes with be[i]=1; be=0 performs no write but still returns ready. MMIO reads are unaffected.
- When undefined: no be port; all writes are full-word.

Decomposition:
- Package dmem_pkg holds:
  - FSM state encoding (IDLE/WAIT/RESP)
  - MMIO offset constants (OFS_CYCLE=0x0, OFS_SCRATCH=0x4, OFS_ACCESS=0x8)
  - wait-counter width constant (4)
- One sub-module, dmem_ram: single-port synchronous-write, asynchronous-read word RAM, parameterised by DEPTH_WORDS, with a byte-enable input tied to 4'hF when the feature is off.

Test Plan (WAIT_STATES=1, DEPTH_WORDS=64 unless stated):
- Write 0xDEADBEEF to 0x10, then read 0x10 -> ready high in cycle 2 after each accepting edge; rd_dm=0xDEADBEEF, err=0.
- Read 0x12; write 0xFFFFFFFF to 0x0E -> err=1, rd_dm=0; a subsequent read of 0x0C is unchanged from its prior value.
- Read 0x100 (first word beyond the RAM) -> err=1, rd_dm=0; the access counter still increments.
- Write 0x12345678 to MMIO_BASE+4, read it back, write 5 to MMIO_BASE+0, then read MMIO_BASE+8 -> readback is 0x12345678, cycle counter is not overwritten, MMIO_BASE+8 returns 3.
- Assert rst=0 during WAIT of a write of 0xA5A5A5A5 to 0x20, then write 0 to 0x20 and read it -> no ready for the aborted access, access counter 0 after reset, 0x20 reads 0.
- WAIT_STATES=0 with req held high for 6 cycles of reads -> ready pulses on alternate cycles, 3 pulses total.
